// File: rtl/ped_pkg.sv
// Shared constants and types for the pedestal row path.
package ped_pkg;
    localparam int unsigned ADC_W        = 14;
    localparam int unsigned MEM_DW       = 16;
    localparam int unsigned PIX_IN_ROW   = 640;
    localparam int unsigned ROW_IN_FRAME = 480;
    localparam int unsigned BANK_W       = 2;
    localparam int unsigned ADDR_W       = 13;

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdStream,
        StWrGap,
        StWrCap,
        StWrCmd,
        StWrDrain,
        StDone
    } state_t;

    typedef struct packed {
        logic              we;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
    } mem_cmd_t;
endpackage

// File: rtl/ped_row_ram.sv
// Simple dual-port row buffer with a one-cycle registered read.
module ped_row_ram #(
    parameter int unsigned Depth = ped_pkg::PIX_IN_ROW,
    parameter int unsigned Width = ped_pkg::ADC_W,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             CLK100,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge CLK100) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end
endmodule

// File: rtl/ped_row_mover.sv
// Row transfer engine: streams memory rows to the pedestal accumulator and
// writes averaged pedestal rows back through a local row buffer.
module ped_row_mover #(
    parameter int unsigned ADC_W      = ped_pkg::ADC_W,
    parameter int unsigned MEM_DW     = ped_pkg::MEM_DW,
    parameter int unsigned PIX_IN_ROW = ped_pkg::PIX_IN_ROW
) (
    input  logic              CLK100,
    input  logic              RESET,
    input  logic              RESET_FRAME,
    input  logic              READ_ROW,
    input  logic              WRITE_ROW,
    input  logic [1:0]        BANK_MEM,
    input  logic [12:0]       ADDR_MEM,
    input  logic [ADC_W-1:0]  PED_DATA,
    output logic [ADC_W-1:0]  DATA_IN,
    output logic              BUFER_EN,
    output logic              NUMBER_CHAN,
    output logic              END_OPERATION,
    output logic              ERR,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [1:0]        mem_cmd_bank,
    output logic [12:0]       mem_cmd_addr,
    input  logic              mem_rd_valid,
    input  logic [MEM_DW-1:0] mem_rd_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [MEM_DW-1:0] mem_wr_data
);
    import ped_pkg::*;

    localparam int unsigned CW = $clog2(PIX_IN_ROW + 1);
    localparam int unsigned AW = $clog2(PIX_IN_ROW);
    localparam logic [CW-1:0] LastWord = CW'(PIX_IN_ROW - 1);
    localparam logic [CW-1:0] RowWords = CW'(PIX_IN_ROW);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             err_q, err_d;
    logic             rd_take;
    logic             bufer_en_q, num_chan_q;
    logic [ADC_W-1:0] data_in_q;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [ADC_W-1:0] ram_rdata;
    logic             unused_rd_msbs;

    assign unused_rd_msbs = ^mem_rd_data[MEM_DW-1:ADC_W];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        err_d         = 1'b0;
        rd_take       = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_raddr     = '0;
        mem_cmd_valid = 1'b0;
        mem_wr_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (READ_ROW) begin
                    state_d = StRdCmd;
                    cmd_d   = mem_cmd_t'{we: 1'b0, bank: BANK_MEM, addr: ADDR_MEM};
                    err_d   = WRITE_ROW;
                end else if (WRITE_ROW) begin
                    state_d = StWrGap;
                    cmd_d   = mem_cmd_t'{we: 1'b1, bank: BANK_MEM, addr: ADDR_MEM};
                end
            end
            StRdCmd: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d = StRdStream;
                    cnt_d   = '0;
                end
            end
            StRdStream: begin
                // Leave one cycle after the last word so END trails it by two.
                if (cnt_q == RowWords) begin
                    state_d = StDone;
                end else if (mem_rd_valid) begin
                    rd_take = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StWrGap: begin
                state_d = StWrCap;
                cnt_d   = '0;
            end
            StWrCap: begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastWord) begin
                    state_d = StWrCmd;
                end
            end
            StWrCmd: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d   = StWrDrain;
                    cnt_d     = '0;
                    ram_re    = 1'b1;
                    ram_raddr = '0;
                end
            end
            StWrDrain: begin
                mem_wr_valid = 1'b1;
                // Fetch the next word on accept so the buffer output never stalls the port.
                if (mem_wr_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        state_d = StDone;
                    end else begin
                        ram_re    = 1'b1;
                        ram_raddr = AW'(cnt_q + 1'b1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle && (READ_ROW || WRITE_ROW)) begin
            err_d = 1'b1;
        end

        if (RESET_FRAME) begin
            state_d = StIdle;
            rd_take = 1'b0;
            ram_we  = 1'b0;
        end
    end

    always_ff @(posedge CLK100 or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cmd_q      <= '0;
            err_q      <= 1'b0;
            bufer_en_q <= 1'b0;
            num_chan_q <= 1'b0;
            data_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            bufer_en_q <= rd_take;
            num_chan_q <= rd_take & cnt_q[0];
            if (rd_take) begin
                data_in_q <= mem_rd_data[ADC_W-1:0];
            end
        end
    end

    ped_row_ram #(
        .Depth (PIX_IN_ROW),
        .Width (ADC_W),
        .AddrW (AW)
    ) u_row_ram (
        .CLK100  (CLK100),
        .wr_en   (ram_we),
        .wr_addr (cnt_q[AW-1:0]),
        .wr_data (PED_DATA),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    assign DATA_IN       = data_in_q;
    assign BUFER_EN      = bufer_en_q;
    assign NUMBER_CHAN   = (state_q == StWrCap) ? cnt_q[0] : num_chan_q;
    assign END_OPERATION = (state_q == StDone);
    assign ERR           = err_q;
    assign mem_cmd_we    = mem_cmd_valid & cmd_q.we;
    assign mem_cmd_bank  = cmd_q.bank;
    assign mem_cmd_addr  = cmd_q.addr;
    assign mem_wr_data   = mem_wr_valid ? {{(MEM_DW - ADC_W){1'b0}}, ram_rdata} : '0;
endmodule

// File: tb/tb_ped_row_mover.sv
// Directed bench for ped_row_mover with an 8-word row.
module tb_ped_row_mover;
    logic        CLK100, RESET, RESET_FRAME, READ_ROW, WRITE_ROW;
    logic [1:0]  BANK_MEM;
    logic [12:0] ADDR_MEM;
    logic [13:0] PED_DATA, DATA_IN;
    logic        BUFER_EN, NUMBER_CHAN, END_OPERATION, ERR;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [1:0]  mem_cmd_bank;
    logic [12:0] mem_cmd_addr;
    logic        mem_rd_valid, mem_wr_valid, mem_wr_ready;
    logic [15:0] mem_rd_data, mem_wr_data;

    int tests = 0;
    int fails = 0;

    ped_row_mover #(
        .ADC_W      (14),
        .MEM_DW     (16),
        .PIX_IN_ROW (8)
    ) dut (
        .CLK100        (CLK100),
        .RESET         (RESET),
        .RESET_FRAME   (RESET_FRAME),
        .READ_ROW      (READ_ROW),
        .WRITE_ROW     (WRITE_ROW),
        .BANK_MEM      (BANK_MEM),
        .ADDR_MEM      (ADDR_MEM),
        .PED_DATA      (PED_DATA),
        .DATA_IN       (DATA_IN),
        .BUFER_EN      (BUFER_EN),
        .NUMBER_CHAN   (NUMBER_CHAN),
        .END_OPERATION (END_OPERATION),
        .ERR           (ERR),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_bank  (mem_cmd_bank),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_data   (mem_wr_data)
    );

    initial CLK100 = 1'b0;
    always #5 CLK100 = ~CLK100;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK100);
        #1;
    endtask

    function automatic logic [51:0] all_outs();
        return {DATA_IN, BUFER_EN, NUMBER_CHAN, END_OPERATION, ERR, mem_cmd_valid, mem_cmd_we,
                mem_cmd_bank, mem_cmd_addr, mem_wr_valid, mem_wr_data};
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        tests++;
        if (all_outs() !== 52'h0) begin
            fails++;
            $display("FAIL reset_outs got %h want 0", all_outs());
        end
        RESET = 1'b0;
        tick();
        tests++;
        if (all_outs() !== 52'h0) begin
            fails++;
            $display("FAIL idle_outs got %h want 0", all_outs());
        end
    endtask

    // gap: rd_valid every gap cycles; stall: cycles of cmd not-ready with stray rd_valid;
    // both: WRITE_ROW alongside READ_ROW; wr_mid: WRITE_ROW during the stream.
    task automatic test_read(input int gap, input int stall, input bit both, input bit wr_mid);
        int          k;
        int          last;
        int          idx;
        bit          v;
        logic [13:0] d;
        BANK_MEM      = 2'd1;
        ADDR_MEM      = 13'h0AA;
        READ_ROW      = 1'b1;
        WRITE_ROW     = both;
        mem_cmd_ready = 1'b0;
        tick();
        READ_ROW  = 1'b0;
        WRITE_ROW = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            tests++;
            if (mem_cmd_valid !== 1'b1 || mem_cmd_we !== 1'b0 || mem_cmd_bank !== 2'd1 ||
                mem_cmd_addr !== 13'h0AA) begin
                fails++;
                $display("FAIL rd_cmd s=%0d got v=%b we=%b bank=%0d addr=%h want 1/0/1/0aa",
                         s, mem_cmd_valid, mem_cmd_we, mem_cmd_bank, mem_cmd_addr);
            end
            tests++;
            if (ERR !== (both && s == 0)) begin
                fails++;
                $display("FAIL rd_cmd_err s=%0d got %b want %b", s, ERR, both && s == 0);
            end
            tests++;
            if (BUFER_EN !== 1'b0) begin
                fails++;
                $display("FAIL stray_rd_before_cmd s=%0d got %b want 0", s, BUFER_EN);
            end
            mem_cmd_ready = (s == stall);
            mem_rd_valid  = (s != stall);
            mem_rd_data   = 16'hBEEF;
            tick();
        end
        mem_cmd_ready = 1'b0;
        k    = 0;
        last = -100;
        for (int c = 0; c < 8 * gap + 4; c++) begin
            v            = (k < 8) && (c % gap == 0);
            mem_rd_valid = v;
            mem_rd_data  = v ? 16'(32'hC010 + k) : 16'hDEAD;
            d            = 14'(32'h10 + k);
            idx          = k;
            WRITE_ROW    = wr_mid && (c == 3);
            if (v) begin
                k++;
                if (k == 8) last = c;
            end
            tick();
            WRITE_ROW = 1'b0;
            tests++;
            if (BUFER_EN !== v) begin
                fails++;
                $display("FAIL rd_bufer_en c=%0d got %b want %b", c + 1, BUFER_EN, v);
            end
            if (v) begin
                tests++;
                if (DATA_IN !== d || NUMBER_CHAN !== idx[0]) begin
                    fails++;
                    $display("FAIL rd_word %0d got data=%h chan=%b want data=%h chan=%b",
                             idx, DATA_IN, NUMBER_CHAN, d, idx[0]);
                end
            end
            tests++;
            if (END_OPERATION !== (c + 1 == last + 2)) begin
                fails++;
                $display("FAIL rd_end c=%0d got %b want %b", c + 1, END_OPERATION,
                         c + 1 == last + 2);
            end
            tests++;
            if (ERR !== (wr_mid && c == 3) || mem_cmd_valid !== 1'b0) begin
                fails++;
                $display("FAIL rd_stream_err c=%0d got err=%b cmd_v=%b want err=%b cmd_v=0",
                         c + 1, ERR, mem_cmd_valid, wr_mid && c == 3);
            end
        end
        mem_rd_valid = 1'b0;
    endtask

    // toggle: mem_wr_ready alternates 1,0 (else held 1); abort_at: words accepted before
    // RESET_FRAME, or -1 to run the full row.
    task automatic test_write(input bit toggle, input int abort_at);
        int  j;
        int  c;
        bit  rdy;
        bit  done;
        BANK_MEM     = 2'd2;
        ADDR_MEM     = 13'h155;
        WRITE_ROW    = 1'b1;
        mem_cmd_ready = 1'b0;
        mem_wr_ready  = 1'b0;
        tick();
        WRITE_ROW = 1'b0;
        tests++;
        if (mem_cmd_valid !== 1'b0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL wr_gap got cmd_v=%b err=%b want 0/0", mem_cmd_valid, ERR);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            PED_DATA = 14'(32'h100 + i);
            tests++;
            if (NUMBER_CHAN !== i[0] || mem_cmd_valid !== 1'b0) begin
                fails++;
                $display("FAIL wr_cap %0d got chan=%b cmd_v=%b want chan=%b cmd_v=0",
                         i, NUMBER_CHAN, mem_cmd_valid, i[0]);
            end
            tick();
        end
        PED_DATA = '0;
        for (int s = 0; s < 2; s++) begin
            tests++;
            if (mem_cmd_valid !== 1'b1 || mem_cmd_we !== 1'b1 || mem_cmd_bank !== 2'd2 ||
                mem_cmd_addr !== 13'h155 || mem_wr_valid !== 1'b0) begin
                fails++;
                $display("FAIL wr_cmd s=%0d got v=%b we=%b bank=%0d addr=%h wv=%b want 1/1/2/155/0",
                         s, mem_cmd_valid, mem_cmd_we, mem_cmd_bank, mem_cmd_addr, mem_wr_valid);
            end
            mem_cmd_ready = (s == 1);
            tick();
        end
        mem_cmd_ready = 1'b0;
        j    = 0;
        c    = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            tests++;
            if (mem_wr_valid !== 1'b1 || mem_wr_data !== 16'(32'h100 + j) ||
                END_OPERATION !== 1'b0) begin
                fails++;
                $display("FAIL wr_drain c=%0d got v=%b data=%h end=%b want 1/%h/0",
                         c, mem_wr_valid, mem_wr_data, END_OPERATION, 16'(32'h100 + j));
            end
            if (abort_at >= 0 && j == abort_at) begin
                RESET_FRAME  = 1'b1;
                mem_wr_ready = 1'b0;
                tick();
                RESET_FRAME = 1'b0;
                for (int a = 0; a < 3; a++) begin
                    tests++;
                    if (mem_wr_valid !== 1'b0 || END_OPERATION !== 1'b0 ||
                        mem_cmd_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL wr_abort a=%0d got wv=%b end=%b cmd_v=%b want 0/0/0",
                                 a, mem_wr_valid, END_OPERATION, mem_cmd_valid);
                    end
                    tick();
                end
                done = 1'b1;
            end else begin
                rdy          = toggle ? (c % 2 == 0) : 1'b1;
                mem_wr_ready = rdy;
                if (rdy) j++;
                tick();
                c++;
                if (j == 8) begin
                    mem_wr_ready = 1'b0;
                    tests++;
                    if (END_OPERATION !== 1'b1 || mem_wr_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL wr_end got end=%b wv=%b want 1/0",
                                 END_OPERATION, mem_wr_valid);
                    end
                    tick();
                    tests++;
                    if (END_OPERATION !== 1'b0) begin
                        fails++;
                        $display("FAIL wr_end_once got %b want 0", END_OPERATION);
                    end
                    done = 1'b1;
                end
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL wr_timeout got %0d words want 8", j);
        end
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        READ_ROW      = 1'b1;
        mem_cmd_ready = 1'b1;
        tick();
        READ_ROW = 1'b0;
        tick();
        mem_cmd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 16'(32'h20 + c);
            tick();
        end
        tests++;
        if (BUFER_EN !== 1'b1 || DATA_IN !== 14'h22) begin
            fails++;
            $display("FAIL arst_pre got en=%b data=%h want 1/022", BUFER_EN, DATA_IN);
        end
        #2 RESET = 1'b1;
        #1;
        tests++;
        if (all_outs() !== 52'h0) begin
            fails++;
            $display("FAIL arst_outs got %h want 0", all_outs());
        end
        tick();
        RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (BUFER_EN !== 1'b0 || END_OPERATION !== 1'b0 || mem_cmd_valid !== 1'b0) begin
                fails++;
                $display("FAIL arst_stray c=%0d got en=%b end=%b cmd_v=%b want 0/0/0",
                         c, BUFER_EN, END_OPERATION, mem_cmd_valid);
            end
        end
        mem_rd_valid = 1'b0;
    endtask

    initial begin
        RESET         = 1'b1;
        RESET_FRAME   = 1'b0;
        READ_ROW      = 1'b0;
        WRITE_ROW     = 1'b0;
        BANK_MEM      = '0;
        ADDR_MEM      = '0;
        PED_DATA      = '0;
        mem_cmd_ready = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = '0;
        mem_wr_ready  = 1'b0;
        test_reset();
        test_read(1, 0, 1'b0, 1'b0);
        test_read(3, 2, 1'b0, 1'b0);
        test_write(1'b1, -1);
        test_read(1, 0, 1'b1, 1'b1);
        test_write(1'b0, 3);
        test_read(1, 0, 1'b0, 1'b0);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
